seg7_monitor: RTL and testbench

Receive-side checker for the active-low seven-segment bus driven by the team's digit-sequencing state machines. It samples the 8-bit segment pattern, qualifies it as stable, and decodes it back to a digit. It then checks that successive digits advance by one with wrap-around and measures the dwell time of each digit in clock cycles. It sits on the board-test and self-check path beside any segment driver.

---
 rtl/seg7_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_seg7_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_monitor.sv
// seg7_monitor: receive-side checker for an active-low seven-segment bus.
// Synchronises and debounces the segment pattern, then decodes it to a digit.
// Checks that digits advance by one with wrap-around and measures digit dwell.
module seg7_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_DIGIT     = 7,
    parameter int unsigned CNT_W         = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       c,
    output logic [3:0]       digit,
    output logic             valid,
    output logic             dp,
    output logic             new_digit,
    output logic             seq_err,
    output logic             bad_code,
    output logic             locked,
    output logic [7:0]       err_cnt,
    output logic [CNT_W-1:0] dwell
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]        MAX_D     = 4'(MAX_DIGIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    logic [7:0]        r_s1;
    logic [7:0]        r_s2;
    logic [7:0]        r_cand;
    logic [STAB_W-1:0] r_stab;
    state_t            r_state;
    logic [3:0]        r_digit;
    logic              r_valid;
    logic              r_dp;
    logic              r_new_digit;
    logic              r_seq_err;
    logic              r_bad_code;
    logic              r_locked;
    logic [7:0]        r_err_cnt;
    logic [CNT_W-1:0]  r_dwell;
    logic [CNT_W-1:0]  r_period;

    logic              w_accept;
    logic              w_blank;
    logic              w_dec_hit;
    logic [3:0]        w_dec_val;
    logic              w_legal;
    logic [3:0]        w_succ;
    state_t            w_state_nxt;
    logic              w_valid_nxt;
    logic [3:0]        w_digit_nxt;
    logic              w_dp_nxt;
    logic              w_new;
    logic              w_seq;
    logic              w_bad;
    logic              w_capture;
    logic [CNT_W-1:0]  w_period_inc;

    // Two-stage synchroniser on the asynchronous segment bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 8'hFF;
            r_s2 <= 8'hFF;
        end else begin
            r_s1 <= c;
            r_s2 <= r_s1;
        end
    end

    // Stability filter: counter saturates so each stable pattern is accepted once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand <= 8'hFF;
            r_stab <= STAB_MAX;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_stab <= '0;
        end else if (r_stab < STAB_MAX) begin
            r_stab <= r_stab + STAB_W'(1);
        end
    end

    assign w_accept = (r_s2 == r_cand) && (r_stab == STAB_LAST);
    assign w_blank  = (r_cand[6:0] == 7'h7F);
    assign w_succ   = (r_digit == MAX_D) ? 4'd0 : (r_digit + 4'd1);

    // Active-low segment decode of the accepted candidate
    always_comb begin
        w_dec_hit = 1'b1;
        w_dec_val = 4'd0;
        case (r_cand[6:0])
            7'b1000000: w_dec_val = 4'd0;
            7'b1111001: w_dec_val = 4'd1;
            7'b0100100: w_dec_val = 4'd2;
            7'b0110000: w_dec_val = 4'd3;
            7'b0011001: w_dec_val = 4'd4;
            7'b0010010: w_dec_val = 4'd5;
            7'b0000010: w_dec_val = 4'd6;
            7'b1111000: w_dec_val = 4'd7;
            7'b0000000: w_dec_val = 4'd8;
            7'b0010000: w_dec_val = 4'd9;
            default:    w_dec_hit = 1'b0;
        endcase
    end

    assign w_legal = w_dec_hit && (w_dec_val <= MAX_D);

    // FSM next state and per-accept actions
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_digit_nxt = r_digit;
        w_dp_nxt    = r_dp;
        w_new       = 1'b0;
        w_seq       = 1'b0;
        w_bad       = 1'b0;
        w_capture   = 1'b0;
        if (w_accept) begin
            if (w_blank) begin
                w_valid_nxt = 1'b0;
            end else if (!w_legal) begin
                w_valid_nxt = 1'b0;
                w_bad       = 1'b1;
            end else if ((w_dec_val == r_digit) && (r_state != IDLE)) begin
                // same digit reappearing (e.g. after a blank) is not a new event
                w_valid_nxt = 1'b1;
            end else begin
                w_valid_nxt = 1'b1;
                w_digit_nxt = w_dec_val;
                w_dp_nxt    = ~r_cand[7];
                w_new       = 1'b1;
                case (r_state)
                    IDLE: begin
                        w_state_nxt = ACQUIRE;
                    end
                    ACQUIRE: begin
                        w_capture   = 1'b1;
                        w_state_nxt = (w_dec_val == w_succ) ? TRACK : ACQUIRE;
                    end
                    TRACK: begin
                        w_capture = 1'b1;
                        if (w_dec_val != w_succ) begin
                            w_seq       = 1'b1;
                            w_state_nxt = ACQUIRE;
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end
        end
    end

    assign w_period_inc = (r_period == '1) ? r_period : (r_period + CNT_W'(1));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, error counter and dwell measurement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_digit     <= 4'd0;
            r_valid     <= 1'b0;
            r_dp        <= 1'b0;
            r_new_digit <= 1'b0;
            r_seq_err   <= 1'b0;
            r_bad_code  <= 1'b0;
            r_locked    <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_dwell     <= '0;
            r_period    <= '0;
        end else begin
            r_digit     <= w_digit_nxt;
            r_valid     <= w_valid_nxt;
            r_dp        <= w_dp_nxt;
            r_new_digit <= w_new;
            r_seq_err   <= w_seq;
            r_bad_code  <= w_bad;
            r_locked    <= (w_state_nxt == TRACK);
            if ((w_seq || w_bad) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_capture) begin
                r_dwell <= w_period_inc;
            end
            r_period <= w_new ? '0 : w_period_inc;
        end
    end

    assign digit     = r_digit;
    assign valid     = r_valid;
    assign dp        = r_dp;
    assign new_digit = r_new_digit;
    assign seq_err   = r_seq_err;
    assign bad_code  = r_bad_code;
    assign locked    = r_locked;
    assign err_cnt   = r_err_cnt;
    assign dwell     = r_dwell;

endmodule

// File: tb/tb_seg7_monitor.sv
// Testbench for seg7_monitor: table of held patterns with expected outputs,
// followed by hand-written saturation and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_seg7_monitor;

    localparam int unsigned CNT_W = 24;

    logic             clk;
    logic             rst;
    logic [7:0]       c;
    logic [3:0]       digit;
    logic             valid;
    logic             dp;
    logic             new_digit;
    logic             seq_err;
    logic             bad_code;
    logic             locked;
    logic [7:0]       err_cnt;
    logic [CNT_W-1:0] dwell;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_monitor #(
        .STABLE_CYCLES(4),
        .MAX_DIGIT    (7),
        .CNT_W        (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .c        (c),
        .digit    (digit),
        .valid    (valid),
        .dp       (dp),
        .new_digit(new_digit),
        .seq_err  (seq_err),
        .bad_code (bad_code),
        .locked   (locked),
        .err_cnt  (err_cnt),
        .dwell    (dwell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern held for 'hold' cycles and the state expected at the end of the window
    typedef struct {
        logic [7:0] pat;
        int         hold;
        int         digit;
        int         valid;
        int         dp;
        int         nd;
        int         bc;
        int         se;
        int         locked;
        int         err;
        int         dwell;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive a pattern and count pulses over n cycles; lat = first cycle new_digit is seen
    task automatic hold(input logic [7:0] pat, input int n,
                        output int nd, output int bc, output int se, output int lat);
        c   = pat;
        nd  = 0;
        bc  = 0;
        se  = 0;
        lat = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (new_digit) begin
                nd++;
                if (lat == 0) lat = i;
            end
            if (bad_code) bc++;
            if (seq_err)  se++;
        end
    endtask

    task automatic check_reset_state(input int idx);
        check("rst_digit",     idx, int'(digit),     0);
        check("rst_valid",     idx, int'(valid),     0);
        check("rst_dp",        idx, int'(dp),        0);
        check("rst_new_digit", idx, int'(new_digit), 0);
        check("rst_seq_err",   idx, int'(seq_err),   0);
        check("rst_bad_code",  idx, int'(bad_code),  0);
        check("rst_locked",    idx, int'(locked),    0);
        check("rst_err_cnt",   idx, int'(err_cnt),   0);
        check("rst_dwell",     idx, int'(dwell),     0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, bc, se, lat;
        int tot_bc;

        //            pat    hold dig val dp nd bc se lck err dwell
        vecs[0]  = '{8'hC0, 100,  0,  1, 0, 1, 0, 0, 0,  0,   0};
        vecs[1]  = '{8'hF9, 100,  1,  1, 0, 1, 0, 0, 1,  0, 100};
        vecs[2]  = '{8'hA4, 100,  2,  1, 0, 1, 0, 0, 1,  0, 100};
        vecs[3]  = '{8'hB0, 100,  3,  1, 0, 1, 0, 0, 1,  0, 100};
        vecs[4]  = '{8'h99, 100,  4,  1, 0, 1, 0, 0, 1,  0, 100};
        vecs[5]  = '{8'h92, 100,  5,  1, 0, 1, 0, 0, 1,  0, 100};
        vecs[6]  = '{8'h82, 100,  6,  1, 0, 1, 0, 0, 1,  0, 100};
        vecs[7]  = '{8'hF8, 100,  7,  1, 0, 1, 0, 0, 1,  0, 100};
        vecs[8]  = '{8'hC0, 100,  0,  1, 0, 1, 0, 0, 1,  0, 100};
        vecs[9]  = '{8'hF9, 100,  1,  1, 0, 1, 0, 0, 1,  0, 100};
        vecs[10] = '{8'h80,   1,  1,  1, 0, 0, 0, 0, 1,  0, 100};
        vecs[11] = '{8'hF9, 100,  1,  1, 0, 0, 0, 0, 1,  0, 100};
        vecs[12] = '{8'hA4, 100,  2,  1, 0, 1, 0, 0, 1,  0, 201};
        vecs[13] = '{8'h99, 100,  4,  1, 0, 1, 0, 1, 0,  1, 100};
        vecs[14] = '{8'h92, 100,  5,  1, 0, 1, 0, 0, 1,  1, 100};
        vecs[15] = '{8'hAA, 100,  5,  0, 0, 0, 1, 0, 1,  2, 100};
        vecs[16] = '{8'hFF, 100,  5,  0, 0, 0, 0, 0, 1,  2, 100};
        vecs[17] = '{8'h92, 100,  5,  1, 0, 0, 0, 0, 1,  2, 100};
        vecs[18] = '{8'h80, 100,  5,  0, 0, 0, 1, 0, 1,  3, 100};

        rst = 1'b0;
        c   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(-1);
        rst = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            hold(vecs[v].pat, vecs[v].hold, nd, bc, se, lat);
            check("digit",     v, int'(digit),   vecs[v].digit);
            check("valid",     v, int'(valid),   vecs[v].valid);
            check("dp",        v, int'(dp),      vecs[v].dp);
            check("locked",    v, int'(locked),  vecs[v].locked);
            check("err_cnt",   v, int'(err_cnt), vecs[v].err);
            check("dwell",     v, int'(dwell),   vecs[v].dwell);
            check("new_digit", v, nd,            vecs[v].nd);
            check("bad_code",  v, bc,            vecs[v].bc);
            check("seq_err",   v, se,            vecs[v].se);
            if (vecs[v].nd > 0) check("latency", v, lat, 7);
        end

        // Saturation: 300 distinct bad codes, alternating so each is accepted
        tot_bc = 0;
        for (int i = 0; i < 300; i++) begin
            hold((i % 2 == 0) ? 8'hAA : 8'h80, 6, nd, bc, se, lat);
            tot_bc += bc;
        end
        hold(8'h80, 10, nd, bc, se, lat);
        tot_bc += bc;
        check("sat_bad_code_cnt", 0, tot_bc, 300);
        check("sat_err_cnt",      0, int'(err_cnt), 255);
        check("sat_valid",        0, int'(valid), 0);
        check("sat_locked",       0, int'(locked), 1);

        // Mid-hold reset: outputs clear asynchronously, then restart from IDLE
        hold(8'h92, 20, nd, bc, se, lat);
        check("pre_rst_valid",     1, int'(valid), 1);
        check("pre_rst_new_digit", 1, nd, 0);
        #3;
        rst = 1'b0;
        #1;
        check_reset_state(1);
        @(posedge clk);
        #1;
        check_reset_state(2);
        rst = 1'b1;

        hold(8'h92, 20, nd, bc, se, lat);
        check("post_rst_new_digit", 3, nd, 1);
        check("post_rst_latency",   3, lat, 7);
        check("post_rst_digit",     3, int'(digit), 5);
        check("post_rst_locked",    3, int'(locked), 0);
        check("post_rst_dwell",     3, int'(dwell), 0);
        check("post_rst_err_cnt",   3, int'(err_cnt), 0);

        // Non-successor from ACQUIRE: new reference, no error; dp set via bit 7 low
        hold(8'h79, 100, nd, bc, se, lat);
        check("acq_new_digit", 4, nd, 1);
        check("acq_seq_err",   4, se, 0);
        check("acq_digit",     4, int'(digit), 1);
        check("acq_dp",        4, int'(dp), 1);
        check("acq_locked",    4, int'(locked), 0);
        check("acq_dwell",     4, int'(dwell), 20);

        hold(8'hA4, 100, nd, bc, se, lat);
        check("relock_digit",  5, int'(digit), 2);
        check("relock_dp",     5, int'(dp), 0);
        check("relock_locked", 5, int'(locked), 1);
        check("relock_dwell",  5, int'(dwell), 100);
        check("relock_err",    5, int'(err_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
